// File: rtl/matrix_read_sequencer.sv
// Streams a rows x cols sub-matrix out of a simple memory, one element
// per cycle, with a registered valid/ready output stage.
module matrix_read_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int SIZE         = 1024,
    parameter int ADDRESS_BITS = $clog2(SIZE + 1),
    parameter int MAX_DIM      = 16,
    parameter int DIM_BITS     = $clog2(MAX_DIM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] base_address,
    input  logic [DIM_BITS-1:0]     num_rows,
    input  logic [DIM_BITS-1:0]     num_cols,
    input  logic [ADDRESS_BITS-1:0] row_stride,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESS_BITS-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last_col,
    output logic                    out_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [DIM_BITS-1:0] LP_MAX = DIM_BITS'(MAX_DIM);
    localparam logic [DIM_BITS-1:0] LP_ONE = DIM_BITS'(1);

    state_t r_state;
    state_t w_state_next;

    logic [DIM_BITS-1:0]     r_rows;
    logic [DIM_BITS-1:0]     r_cols;
    logic [DIM_BITS-1:0]     r_row;
    logic [DIM_BITS-1:0]     r_col;
    logic [ADDRESS_BITS-1:0] r_stride;
    logic [ADDRESS_BITS-1:0] r_row_base;
    logic [ADDRESS_BITS-1:0] r_addr_hold;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_last_col;
    logic                    r_last;
    logic                    r_done;

    logic [DIM_BITS-1:0]     w_rows_clamp;
    logic [DIM_BITS-1:0]     w_cols_clamp;
    logic                    w_zero_dim;
    logic                    w_start_idle;
    logic                    w_fetch;
    logic                    w_col_last;
    logic                    w_row_last;
    logic                    w_drain_hs;
    logic                    w_done_next;
    logic [ADDRESS_BITS-1:0] w_addr;

    assign w_rows_clamp = (num_rows > LP_MAX) ? LP_MAX : num_rows;
    assign w_cols_clamp = (num_cols > LP_MAX) ? LP_MAX : num_cols;
    assign w_zero_dim   = (w_rows_clamp == '0) || (w_cols_clamp == '0);
    assign w_start_idle = (r_state == IDLE) && start;

    assign w_fetch    = (r_state == RUN) && (!r_valid || out_ready);
    assign w_col_last = (r_col == r_cols - LP_ONE);
    assign w_row_last = (r_row == r_rows - LP_ONE);
    assign w_drain_hs = (r_state == DRAIN) && r_valid && out_ready;
    assign w_addr     = r_row_base + ADDRESS_BITS'(r_col);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and completion pulse
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero_dim) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (w_fetch && w_col_last && w_row_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_hs) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Transfer parameters and walk counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows      <= '0;
            r_cols      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_stride    <= '0;
            r_row_base  <= '0;
            r_addr_hold <= '0;
        end else begin
            if (w_start_idle) begin
                r_rows     <= w_rows_clamp;
                r_cols     <= w_cols_clamp;
                r_stride   <= row_stride;
                r_row_base <= base_address;
                r_row      <= '0;
                r_col      <= '0;
            end
            if (r_state == RUN) begin
                r_addr_hold <= w_addr;
            end
            if (w_fetch) begin
                if (w_col_last) begin
                    r_col      <= '0;
                    r_row      <= r_row + LP_ONE;
                    r_row_base <= r_row_base + r_stride;
                end else begin
                    r_col <= r_col + LP_ONE;
                end
            end
        end
    end

    // Registered output stage; holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last_col <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_fetch) begin
                r_data     <= mem_read_data;
                r_valid    <= 1'b1;
                r_last_col <= w_col_last;
                r_last     <= w_col_last && w_row_last;
            end else if (w_drain_hs) begin
                r_valid    <= 1'b0;
                r_last_col <= 1'b0;
                r_last     <= 1'b0;
            end
        end
    end

    assign mem_read_address = (r_state == RUN) ? w_addr : r_addr_hold;
    assign busy             = (r_state != IDLE);
    assign done             = r_done;
    assign out_valid        = r_valid;
    assign out_data         = r_data;
    assign out_last_col     = r_last_col;
    assign out_last         = r_last;

endmodule

// File: tb/tb_matrix_read_sequencer.sv
// Directed bench for matrix_read_sequencer; memory model returns a & 0xFF.
module tb_matrix_read_sequencer;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int DB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [DB-1:0] num_rows;
    logic [DB-1:0] num_cols;
    logic [AW-1:0] row_stride;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last_col;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [DB-1:0] rows;
        logic [DB-1:0] cols;
        logic [AW-1:0] stride;
        int            pat;
        bit            spam;
        int            n;
        logic [127:0]  data;
        logic [15:0]   lc;
        logic [AW-1:0] hold;
    } vec_t;

    matrix_read_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_address     (base_address),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .row_stride       (row_stride),
        .busy             (busy),
        .done             (done),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last_col     (out_last_col),
        .out_last         (out_last)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem_read_address[7:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic vec_t mk(logic [AW-1:0] b, logic [DB-1:0] r,
                                logic [DB-1:0] c, logic [AW-1:0] s,
                                int p, bit sp, int n, logic [127:0] d,
                                logic [15:0] lc, logic [AW-1:0] h);
        vec_t v;
        v.base = b; v.rows = r; v.cols = c; v.stride = s;
        v.pat = p; v.spam = sp; v.n = n; v.data = d;
        v.lc = lc; v.hold = h;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int n = 0;
        int cyc = 1;
        int first = -1;
        int done_cyc = -1;
        int last_hs = -1;
        logic pstall = 1'b0;
        logic [DW-1:0] pdata = '0;
        base_address = v.base;
        num_rows = v.rows;
        num_cols = v.cols;
        row_stride = v.stride;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("accept_busy", busy, 1);
        while (cyc < 200 && done_cyc < 0) begin
            if (out_valid && first < 0) first = cyc;
            if (pstall) chk("stall_hold", out_data, pdata);
            if (done) begin
                done_cyc = cyc;
                chk("idle_at_done", busy, 0);
                chk("valid_at_done", out_valid, 0);
            end else begin
                out_ready = (v.pat == 0) ? 1'b1 : (cyc % 3 == 1);
                start = v.spam && busy && (cyc % 2 == 0);
                base_address = start ? 11'h100 : v.base;
                if (out_valid && out_ready) begin
                    if (n < v.n) begin
                        chk("data", out_data, v.data[8*n +: 8]);
                        chk("last_col", out_last_col, v.lc[n]);
                        chk("last", out_last, n == v.n - 1);
                    end else begin
                        fail("extra_element");
                    end
                    n++;
                    last_hs = cyc;
                end
                pstall = out_valid && !out_ready;
                pdata = out_data;
                step();
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        base_address = v.base;
        if (done_cyc < 0) fail("done_timeout");
        chk("count", n, v.n);
        chk("done_latency", done_cyc, last_hs + 1);
        chk("hold_addr", mem_read_address, v.hold);
        if (v.pat == 0) chk("first_valid_cyc", first, 2);
        step();
        chk("done_pulse", done, 0);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = mk(11'h010, 2, 3, 8, 0, 0, 6,
                   128'h1A1918121110, 16'h0024, 11'h01A);
        vt[1] = mk(11'h010, 2, 3, 8, 1, 0, 6,
                   128'h1A1918121110, 16'h0024, 11'h01A);
        vt[2] = mk(11'h7FE, 1, 3, 0, 0, 0, 3,
                   128'h00FFFE, 16'h0004, 11'h000);
        vt[3] = mk(11'h3FF, 1, 2, 0, 0, 0, 2,
                   128'h00FF, 16'h0002, 11'h400);
        vt[4] = mk(11'h000, 20, 1, 1, 0, 1, 16,
                   128'h0F0E0D0C0B0A09080706050403020100,
                   16'hFFFF, 11'h00F);
        vt[5] = mk(11'h005, 3, 2, 11'h100, 1, 0, 6,
                   128'h060506050605, 16'h002A, 11'h206);
        vt[6] = mk(11'h020, 1, 20, 0, 0, 0, 16,
                   128'h2F2E2D2C2B2A29282726252423222120,
                   16'h8000, 11'h02F);
        vt[7] = mk(11'h040, 4, 4, 4, 0, 0, 16,
                   128'h4F4E4D4C4B4A49484746454443424140,
                   16'h8888, 11'h04F);

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        base_address = '0;
        num_rows = '0;
        num_cols = '0;
        row_stride = '0;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", mem_read_address, 0);
        chk("rst_last", {out_last, out_last_col}, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Zero dimension: done next cycle, no elements
        num_rows = 0;
        num_cols = 5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_valid", out_valid, 0);
        chk("zero_done", done, 1);
        // Start accepted in the done cycle
        run_vec(vt[0]);

        num_rows = 3;
        num_cols = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero2_done", done, 1);
        chk("zero2_busy", busy, 0);
        step();
        chk("zero2_pulse", done, 0);
        chk("zero2_valid", out_valid, 0);

        // Reset after the second handshake of a 4x4 transfer
        begin
            int hs = 0;
            int k = 0;
            base_address = 11'h040;
            num_rows = 4;
            num_cols = 4;
            row_stride = 4;
            start = 1'b1;
            step();
            start = 1'b0;
            while (hs < 2 && k < 20) begin
                if (out_valid && out_ready) hs++;
                if (hs < 2) step();
                k++;
            end
            if (hs < 2) fail("mid_hs_timeout");
            step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("mid_valid", out_valid, 0);
            chk("mid_busy", busy, 0);
            chk("mid_done", done, 0);
            chk("mid_addr", mem_read_address, 0);
            for (int j = 0; j < 5; j++) begin
                step();
                chk("post_rst_valid", out_valid, 0);
                chk("post_rst_done", done, 0);
            end
        end
        run_vec(vt[7]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
